// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with round-to-nearest-even.
// Subnormal inputs are flushed to zero, and tiny results flush to signed zero.
// Stage 1 aligns the operands, stage 2 adds and normalises, and stage 3 rounds
// and packs the result. Special operands bypass the arithmetic and travel down
// the pipe with their precomputed result.
module fpu_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int NUM_OP = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NUM_OP-1:0]        i_alu_op,
  input  logic [EXP_W+MAN_W:0]     i_data_a,
  input  logic [EXP_W+MAN_W:0]     i_data_b,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic [3:0]               o_flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;

  // Stage 1 combinational signals
  logic               sign_a, sign_b;
  logic [EXP_W-1:0]   exp_a, exp_b;
  logic [MAN_W-1:0]   frac_a, frac_b;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic               a_ge_b;
  logic               big_sign, small_sign;
  logic [EXP_W-1:0]   big_exp, small_exp, exp_diff;
  logic [MAN_W-1:0]   big_frac, small_frac;
  logic [SW-1:0]      small_full, shift_mask, small_align;
  logic               spec_hit;
  logic [W-1:0]       spec_res;
  logic [3:0]         spec_flags;

  // Stage 1 registers
  logic               s1_valid, s1_special, s1_sign, s1_sub;
  logic [W-1:0]       s1_spec_res;
  logic [3:0]         s1_spec_flags;
  logic [EXP_W-1:0]   s1_exp;
  logic [SW-1:0]      s1_big, s1_small;

  // Stage 2 combinational signals
  logic [SW:0]        sum;
  logic [LZW-1:0]     lzc;
  logic [SW-1:0]      norm_sig;
  logic [EW-1:0]      norm_exp;
  logic               sum_zero;

  // Stage 2 registers
  logic               s2_valid, s2_special, s2_sign, s2_zero;
  logic [W-1:0]       s2_spec_res;
  logic [3:0]         s2_spec_flags;
  logic [EW-1:0]      s2_exp;
  logic [SW-1:0]      s2_sig;

  // Stage 3 combinational signals
  logic [MAN_W:0]     mant;
  logic               guard, rnd, stky, round_up, inexact;
  logic [MAN_W+1:0]   rounded;
  logic [MAN_W-1:0]   rnd_frac;
  logic [EW-1:0]      rnd_exp;
  logic [W-1:0]       res_word;
  logic [3:0]         res_flags;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Unpack, classify, order by magnitude and align the smaller significand
  always_comb begin
    sign_a = i_data_a[W-1];
    exp_a  = i_data_a[W-2:MAN_W];
    frac_a = i_data_a[MAN_W-1:0];
    sign_b = i_data_b[W-1] ^ i_alu_op[0];
    exp_b  = i_data_b[W-2:MAN_W];
    frac_b = i_data_b[MAN_W-1:0];

    a_zero = (exp_a == '0);
    b_zero = (exp_b == '0);
    a_inf  = (exp_a == EXP_ONES) && (frac_a == '0);
    b_inf  = (exp_b == EXP_ONES) && (frac_b == '0);
    a_nan  = (exp_a == EXP_ONES) && (frac_a != '0);
    b_nan  = (exp_b == EXP_ONES) && (frac_b != '0);
    a_snan = a_nan && !frac_a[MAN_W-1];
    b_snan = b_nan && !frac_b[MAN_W-1];

    a_ge_b = {exp_a, frac_a} >= {exp_b, frac_b};
    if (a_ge_b) begin
      big_sign   = sign_a;
      big_exp    = exp_a;
      big_frac   = frac_a;
      small_sign = sign_b;
      small_exp  = exp_b;
      small_frac = frac_b;
    end else begin
      big_sign   = sign_b;
      big_exp    = exp_b;
      big_frac   = frac_b;
      small_sign = sign_a;
      small_exp  = exp_a;
      small_frac = frac_a;
    end

    exp_diff   = big_exp - small_exp;
    small_full = {1'b1, small_frac, 3'b000};
    shift_mask = ~({SW{1'b1}} << exp_diff);
    if (exp_diff > EXP_W'(SW - 1))
      small_align = {{(SW-1){1'b0}}, 1'b1};
    else
      small_align = (small_full >> exp_diff) |
                    {{(SW-1){1'b0}}, |(small_full & shift_mask)};
  end

  // Special operands (NaN, Inf, zero) resolve here and skip the arithmetic
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res   = QNAN;
      spec_flags = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf) begin
      if (sign_a != sign_b) begin
        spec_res   = QNAN;
        spec_flags = 4'b1000;
      end else begin
        spec_res = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      spec_res = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_res = {sign_a & sign_b, {(W-1){1'b0}}};
    end else if (b_zero) begin
      spec_res = i_data_a;
    end else if (a_zero) begin
      spec_res = {sign_b, exp_b, frac_b};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Stage 1 register: captures a new operand pair whenever the pipe advances
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid      <= 1'b0;
      s1_special    <= 1'b0;
      s1_spec_res   <= '0;
      s1_spec_flags <= '0;
      s1_sign       <= 1'b0;
      s1_sub        <= 1'b0;
      s1_exp        <= '0;
      s1_big        <= '0;
      s1_small      <= '0;
    end else if (adv) begin
      s1_valid      <= i_valid;
      s1_special    <= spec_hit;
      s1_spec_res   <= spec_res;
      s1_spec_flags <= spec_flags;
      s1_sign       <= big_sign;
      s1_sub        <= big_sign != small_sign;
      s1_exp        <= big_exp;
      s1_big        <= {1'b1, big_frac, 3'b000};
      s1_small      <= small_align;
    end
  end

  // Add or subtract the aligned significands, then normalise
  always_comb begin
    if (s1_sub)
      sum = {1'b0, s1_big} - {1'b0, s1_small};
    else
      sum = {1'b0, s1_big} + {1'b0, s1_small};

    lzc = '0;
    for (int i = 0; i < SW; i++)
      if (sum[i]) lzc = LZW'(SW - 1 - i);

    sum_zero = (sum == '0);
    if (sum[SW]) begin
      norm_sig = {sum[SW:2], sum[1] | sum[0]};
      norm_exp = {2'b00, s1_exp} + EW'(1);
    end else begin
      norm_sig = sum[SW-1:0] << lzc;
      norm_exp = {2'b00, s1_exp} - EW'(lzc);
    end
  end

  // Stage 2 register: normalised significand and working exponent
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid      <= 1'b0;
      s2_special    <= 1'b0;
      s2_spec_res   <= '0;
      s2_spec_flags <= '0;
      s2_sign       <= 1'b0;
      s2_zero       <= 1'b0;
      s2_exp        <= '0;
      s2_sig        <= '0;
    end else if (adv) begin
      s2_valid      <= s1_valid;
      s2_special    <= s1_special;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
      s2_sign       <= s1_sign;
      s2_zero       <= sum_zero;
      s2_exp        <= norm_exp;
      s2_sig        <= norm_sig;
    end
  end

  // Round to nearest even, detect overflow/underflow and pack the word
  always_comb begin
    mant     = s2_sig[SW-1:3];
    guard    = s2_sig[2];
    rnd      = s2_sig[1];
    stky     = s2_sig[0];
    inexact  = guard | rnd | stky;
    round_up = guard && (rnd || stky || mant[0]);
    rounded  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    rnd_frac = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    rnd_exp  = s2_exp + {{(EW-1){1'b0}}, rounded[MAN_W+1]};

    res_word  = '0;
    res_flags = '0;
    if (s2_special) begin
      res_word  = s2_spec_res;
      res_flags = s2_spec_flags;
    end else if (s2_zero) begin
      res_word  = '0;
    end else if ($signed(rnd_exp) >= $signed(EW'(EMAX))) begin
      res_word  = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else if ($signed(rnd_exp) <= $signed(EW'(0))) begin
      res_word  = {s2_sign, {(W-1){1'b0}}};
      res_flags = 4'b0011;
    end else begin
      res_word  = {s2_sign, rnd_exp[EXP_W-1:0], rnd_frac};
      res_flags = {3'b000, inexact};
    end
  end

  // Output register: holds the result steady while downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else if (adv) begin
      o_valid  <= s2_valid;
      o_result <= res_word;
      o_flags  <= res_flags;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Self-checking bench for fpu_addsub_pipe. An exact-arithmetic reference model
// (wide integer sums, rounded once) predicts every result; a scoreboard queue
// orders predictions, and a single monitor compares them on each output transfer.
module tb_fpu_addsub_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 21;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [0:0]  i_alu_op;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  int num_checks = 0;
  int num_fails  = 0;
  logic [35:0] exp_q[$];
  vec_t vecs[NV];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flg;
  logic [35:0] mon_exp;

  fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23), .NUM_OP(1)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_alu_op (i_alu_op),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Exact reference: align both significands as wide integers, add, round once.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic op);
    logic sa, sb, sr, inx;
    int ea, eb, emin, p, sh, eres;
    logic [22:0] fa, fb;
    logic [319:0] ma, mb, mag, q, rem, half, one;
    sa = a[31];
    sb = b[31] ^ op;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))
      return {((ea == 255 && fa != 0 && !fa[22]) || (eb == 255 && fb != 0 && !fb[22])),
              3'b000, 32'h7FC00000};
    if (ea == 255 && eb == 255)
      return (sa != sb) ? {4'b1000, 32'h7FC00000} : {4'b0000, sa, 31'h7F800000};
    if (ea == 255) return {4'b0000, sa, 31'h7F800000};
    if (eb == 255) return {4'b0000, sb, 31'h7F800000};
    if (ea == 0 && eb == 0) return {4'b0000, sa & sb, 31'h0};
    if (eb == 0) return {4'b0000, a};
    if (ea == 0) return {4'b0000, sb, b[30:0]};
    emin = (ea < eb) ? ea : eb;
    one  = 1;
    ma = {296'b0, 1'b1, fa} << (ea - emin);
    mb = {296'b0, 1'b1, fb} << (eb - emin);
    if (sa == sb) begin
      mag = ma + mb; sr = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sr = sa;
    end else begin
      mag = mb - ma; sr = sb;
    end
    if (mag == 0) return 36'h0;
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    eres = p + emin - 23;
    inx  = 1'b0;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + one;
      if (q[24]) begin
        q = q >> 1;
        eres++;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (eres >= 255) return {4'b0101, sr, 31'h7F800000};
    if (eres <= 0)   return {4'b0011, sr, 31'h0};
    return {3'b000, inx, sr, 8'(eres), q[22:0]};
  endfunction

  // Present one operand pair and wait (bounded) until it is accepted
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op);
    i_valid  = 1'b1;
    i_data_a = a;
    i_data_b = b;
    i_alu_op = op;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        exp_q.push_back(model(a, b, op));
        @(posedge i_clk);
        #1;
        return;
      end
      @(posedge i_clk);
      #1;
    end
    checkOutput("accept_timeout", o_ready, 1);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge i_clk);
    #1;
    checkOutput("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: handshake rule, stall hold, and in-order scoreboard compare
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      checkOutput("o_ready_rule", o_ready, !o_valid || i_ready);
      if (prev_stall) begin
        checkOutput("stall_hold_valid", o_valid, 1);
        checkOutput("stall_hold_result", {o_flags, o_result}, {prev_flg, prev_res});
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", o_valid, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("result", o_result, mon_exp[31:0]);
          checkOutput("flags", o_flags, mon_exp[35:32]);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_res   = o_result;
      prev_flg   = o_flags;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
    vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
    vecs[6]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1};
    vecs[7]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0};
    vecs[8]  = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'h0};
    vecs[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
    vecs[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
    vecs[11] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0};
    vecs[12] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'h0};
    vecs[13] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'h0};
    vecs[14] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'h3};
    vecs[15] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0};
    vecs[16] = '{32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'h0};
    vecs[17] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0};
    vecs[18] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'h0};
    vecs[19] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
    vecs[20] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'h0};

    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_alu_op = 1'b0;
    i_data_a = '0;
    i_data_b = '0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_o_valid", o_valid, 0);
    checkOutput("reset_o_result", o_result, 0);
    checkOutput("reset_o_flags", o_flags, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("reset_o_ready", o_ready, 1);

    // Pin the reference model to hand-computed values
    for (int v = 0; v < NV; v++)
      checkOutput($sformatf("model_pin_%0d", v), model(vecs[v].a, vecs[v].b, vecs[v].op),
                  {vecs[v].flg, vecs[v].res});

    // Latency: 1.0 + 1.0 appears exactly three cycles after acceptance
    applyStimulus(vecs[0].a, vecs[0].b, vecs[0].op);
    i_valid = 1'b0;
    checkOutput("latency_cycle1", o_valid, 0);
    @(posedge i_clk); #1;
    checkOutput("latency_cycle2", o_valid, 0);
    @(posedge i_clk); #1;
    checkOutput("latency_cycle3", o_valid, 1);
    checkOutput("latency_result", o_result, 32'h40000000);
    checkOutput("latency_flags", o_flags, 4'h0);
    waitDrain();

    // All directed vectors back to back
    for (int v = 0; v < NV; v++)
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].op);
    i_valid = 1'b0;
    waitDrain();

    // Eight-op stream with a two-cycle downstream stall in the middle
    fork
      begin
        for (int v = 0; v < 8; v++)
          applyStimulus(vecs[v + 3].a, vecs[v + 3].b, vecs[v + 3].op);
        i_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge i_clk);
        #1 i_ready = 1'b0;
        #4 checkOutput("stall_o_ready_low", o_ready, 0);
        repeat (2) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset with three operations in flight
    i_ready = 1'b0;
    for (int v = 0; v < 3; v++)
      applyStimulus(vecs[v + 5].a, vecs[v + 5].b, vecs[v + 5].op);
    i_valid = 1'b0;
    checkOutput("inflight_o_valid", o_valid, 1);
    i_rst = 1'b1;
    #1;
    checkOutput("midreset_o_valid", o_valid, 0);
    checkOutput("midreset_o_result", o_result, 0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      checkOutput("no_stale_result", o_valid, 0);
    end
    @(posedge i_clk);
    #1;

    // Recovery after reset
    applyStimulus(vecs[8].a, vecs[8].b, vecs[8].op);
    i_valid = 1'b0;
    waitDrain();

    repeat (2) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
